// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the processor run/halt/step controller: FSM state
// encoding, the default halt instruction word and the 2-bit display code.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BREAK = 3'd3,
    ST_DONE  = 3'd4
  } run_state_e;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  localparam logic [1:0] DISP_HALT  = 2'd0;
  localparam logic [1:0] DISP_RUN   = 2'd1;
  localparam logic [1:0] DISP_STEP  = 2'd2;
  localparam logic [1:0] DISP_BREAK = 2'd3;

  // DONE shares the BREAK display code; the separate done flag tells them apart.
  function automatic logic [1:0] state_disp(input run_state_e s);
    case (s)
      ST_HALT:  return DISP_HALT;
      ST_RUN:   return DISP_RUN;
      ST_STEP:  return DISP_STEP;
      default:  return DISP_BREAK;
    endcase
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse
// for an asynchronous board button.
module debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter tracks consecutive cycles where the synchronised input
  // disagrees with the accepted level; any agreement restarts the wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      sync_q  <= {sync_q[0], raw_i};
      pulse_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          pulse_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the single-cycle datapath: issues the
// per-cycle commit enable, handles breakpoint and halt instruction, counts cycles.
module cpu_run_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] HALT_INSTR      = HALT_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        bp_en,
  input  logic [31:0] bp_addr,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        cpu_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic        done,
  output logic [31:0] cycle_count,
  output logic [31:0] retired_count
);

  logic [1:0]  run_sync_q;
  logic        run_sw_s;
  logic        step_pulse;
  run_state_e  state_q, state_d;
  logic        skip_bp_q, skip_bp_d;
  logic        bp_hit, halt_hit;
  logic        halted_q, done_q;
  logic [1:0]  state_disp_q;
  logic [31:0] cycle_q, retired_q;

  debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_step_db (
    .clk     (clk),
    .reset   (reset),
    .raw_i   (step_btn),
    .pulse_o (step_pulse)
  );

  assign run_sw_s = run_sync_q[1];
  assign bp_hit   = bp_en && (pc == bp_addr) && !skip_bp_q;
  assign halt_hit = (instr == HALT_INSTR);

  // A matched breakpoint or halt word suppresses commit in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    cpu_en = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_RUN:  cpu_en = !bp_hit && !halt_hit;
        ST_STEP: cpu_en = !halt_hit;
        default: cpu_en = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_bp_d = skip_bp_q;
    case (state_q)
      ST_HALT: begin
        if (run_sw_s) begin
          state_d   = ST_RUN;
          skip_bp_d = 1'b1;
        end else if (step_pulse) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        skip_bp_d = 1'b0;
        if (halt_hit)       state_d = ST_DONE;
        else if (bp_hit)    state_d = ST_BREAK;
        else if (!run_sw_s) state_d = ST_HALT;
      end
      ST_STEP:  state_d = halt_hit ? ST_DONE : ST_HALT;
      ST_BREAK: begin
        if (step_pulse)     state_d = ST_STEP;
        else if (!run_sw_s) state_d = ST_HALT;
      end
      default:  state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_sync_q   <= 2'b00;
      state_q      <= ST_HALT;
      skip_bp_q    <= 1'b0;
      halted_q     <= 1'b1;
      done_q       <= 1'b0;
      state_disp_q <= DISP_HALT;
      cycle_q      <= '0;
      retired_q    <= '0;
    end else begin
      run_sync_q   <= {run_sync_q[0], run_sw};
      state_q      <= state_d;
      skip_bp_q    <= skip_bp_d;
      halted_q     <= (state_d == ST_HALT) || (state_d == ST_BREAK) || (state_d == ST_DONE);
      done_q       <= (state_d == ST_DONE);
      state_disp_q <= state_disp(state_d);
      cycle_q      <= cycle_q + 32'd1;
      if (cpu_en) retired_q <= retired_q + 32'd1;
    end
  end

  assign halted        = halted_q;
  assign done          = done_q;
  assign state         = state_disp_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl: a cycle-level behavioural model queues
// expected outputs per cycle; a negedge monitor pops and compares them.
module tb_cpu_run_ctrl;

  localparam int unsigned DB     = 16;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] BP_PC  = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        reset, run_sw, step_btn, bp_en;
  logic [31:0] bp_addr, pc, instr;
  logic        cpu_en, halted, done;
  logic [1:0]  state;
  logic [31:0] cycle_count, retired_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(DB), .HALT_INSTR(HALT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .run_sw        (run_sw),
    .step_btn      (step_btn),
    .bp_en         (bp_en),
    .bp_addr       (bp_addr),
    .pc            (pc),
    .instr         (instr),
    .cpu_en        (cpu_en),
    .halted        (halted),
    .state         (state),
    .done          (done),
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
  );

  typedef struct {
    logic        cpu_en;
    logic        halted;
    logic [1:0]  state;
    logic        done;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle.
  exp_t e;
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("cpu_en",        32'(cpu_en),   32'(e.cpu_en));
      check("halted",        32'(halted),   32'(e.halted));
      check("state",         32'(state),    32'(e.state));
      check("done",          32'(done),     32'(e.done));
      check("cycle_count",   cycle_count,   e.cyc);
      check("retired_count", retired_count, e.ret);
    end
  end

  // Reference model, expressed as the controller's rules over input history.
  typedef enum int {M_HALT, M_RUN, M_STEP, M_BREAK, M_DONE} mstate_e;
  mstate_e     mst;
  logic        m_skip;
  logic        run_h1, run_h2, btn_h1, btn_h2;
  logic        level, pulse;
  logic        btn_win[$];
  logic [31:0] cyc, ret, pc_m;

  function automatic logic [1:0] disp(input mstate_e s);
    case (s)
      M_HALT:  return 2'd0;
      M_RUN:   return 2'd1;
      M_STEP:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic model_reset();
    mst = M_HALT; m_skip = 1'b0;
    run_h1 = 1'b0; run_h2 = 1'b0; btn_h1 = 1'b0; btn_h2 = 1'b0;
    level = 1'b0; pulse = 1'b0; btn_win.delete();
    cyc = '0; ret = '0;
  endtask

  task automatic tick(input logic rst, input logic rs, input logic sb, input logic hi, input logic bpe);
    exp_t    x;
    logic    bph, hh, en, run_s, all_flip;
    mstate_e nxt;
    @(posedge clk); #1;
    reset = rst; run_sw = rs; step_btn = sb; bp_en = bpe;
    pc    = pc_m;
    instr = hi ? HALT_W : ($urandom & 32'h7FFF_FFFF);
    run_s = run_h2;
    bph   = bpe && (pc_m == BP_PC) && !m_skip;
    hh    = hi;
    en    = !rst && ((mst == M_RUN && !bph && !hh) || (mst == M_STEP && !hh));
    x.cpu_en = en;
    x.halted = (mst == M_HALT) || (mst == M_BREAK) || (mst == M_DONE);
    x.state  = disp(mst);
    x.done   = (mst == M_DONE);
    x.cyc    = cyc;
    x.ret    = ret;
    sb_q.push_back(x);
    if (rst) begin
      model_reset();
    end else begin
      nxt = mst;
      case (mst)
        M_HALT:  if (run_s) begin nxt = M_RUN; m_skip = 1'b1; end
                 else if (pulse) nxt = M_STEP;
        M_RUN:   begin
                   m_skip = 1'b0;
                   if (hh) nxt = M_DONE;
                   else if (bph) nxt = M_BREAK;
                   else if (!run_s) nxt = M_HALT;
                 end
        M_STEP:  nxt = hh ? M_DONE : M_HALT;
        M_BREAK: if (pulse) nxt = M_STEP;
                 else if (!run_s) nxt = M_HALT;
        default: nxt = M_DONE;
      endcase
      mst = nxt;
      // Debounced level flips once the last DB synchronised samples all disagree with it.
      btn_win.push_back(btn_h2);
      if (btn_win.size() > DB) void'(btn_win.pop_front());
      all_flip = (btn_win.size() == DB);
      foreach (btn_win[i]) if (btn_win[i] == level) all_flip = 1'b0;
      pulse = 1'b0;
      if (all_flip) begin
        level = !level;
        pulse = level;
      end
      run_h2 = run_h1; run_h1 = rs;
      btn_h2 = btn_h1; btn_h1 = sb;
      cyc = cyc + 32'd1;
      if (en) ret = ret + 32'd1;
    end
    if (en) pc_m = (pc_m + 32'd4) & 32'h0000_003F;
  endtask

  initial begin
    logic rs, bpe;
    int   btn_left;
    reset = 1'b1; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0;
    bp_addr = BP_PC; pc = '0; instr = '0;
    pc_m = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset, then run freely.
    repeat (2)  tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (16) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6)  tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Single step, then a short glitch that must not step.
    repeat (DB + 5) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (DB + 5) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5)      tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (25)     tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Breakpoint at 0x10, step over it, resume and re-break, then stop.
    repeat (30)     tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (DB + 4) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (40)     tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (6)      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    // Halt instruction while running, then try to escape DONE.
    repeat (8)      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (6)      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (DB + 4) tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4)      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4)      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Run rise and step pulse land in the same HALT cycle.
    repeat (DB)     tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10)     tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6)      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised mix of switch toggles, presses, glitches, halts and resets.
    rs = 1'b0; bpe = 1'b1; btn_left = 0;
    for (int c = 0; c < 2000; c++) begin
      logic sb, hi, rst;
      if ($urandom_range(0, 39) == 0) rs = ~rs;
      if (c % 250 == 0) bpe = ~bpe;
      sb = 1'b0;
      if (btn_left > 0) begin
        sb = 1'b1;
        btn_left--;
      end else if ($urandom_range(0, 29) == 0) begin
        btn_left = $urandom_range(1, DB + 8);
      end
      hi  = ($urandom_range(0, 299) == 0);
      rst = ($urandom_range(0, 399) == 0);
      tick(rst, rs, sb, hi, bpe);
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the single-cycle processor datapath. It issues the per-cycle `cpu_en` that gates PC update, register-file write and data-memory write. It also provides a PC breakpoint, halt-instruction detection, and retired-instruction and cycle counters for the board display. It sits between the board switches and buttons and the datapath top level.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 16, stable cycles required before `step_btn` is accepted (board build overrides with a larger value).
- HALT_INSTR, 32'hFFFF_FFFF, instruction word that stops the processor permanently.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- run_sw  input  1  asynchronous board switch; 1 = run freely.
- step_btn  input  1  asynchronous board button; each debounced press executes one instruction.
- bp_en  input  1  breakpoint enable.
- bp_addr  input  32  breakpoint PC.
- pc  input  32  current PC from the datapath.
- instr  input  32  instruction word currently presented to the decoder.
- cpu_en  output  1  datapath commit enable for this cycle.
- halted  output  1  high in HALT, BREAK and DONE.
- state  output  2  current FSM state: HALT=0, RUN=1, STEP=2, BREAK=3; DONE is reported as 3 with `done`=1.
- done  output  1  halt instruction reached.
- cycle_count  output  32  clocks since reset.
- retired_count  output  32  cycles with `cpu_en`=1.

## Operation
- **Synchronisers:** `run_sw` and `step_btn` each pass through a 2-flop synchroniser.
- **Step debounce:** `step_btn` must be stable for DEBOUNCE_CYCLES before the debounced level changes. A rising edge of the debounced level produces a one-cycle `step_pulse`.
- **Derived signals:**
  - `bp_hit` = `bp_en` && (`pc` == `bp_addr`) && !`skip_bp`.
  - `halt_hit` = (`instr` == HALT_INSTR).
- **cpu_en (combinational from registered state and inputs):**
  - In RUN: 1 when !`bp_hit` && !`halt_hit`.
  - In STEP: 1 when !`halt_hit`.
  - Otherwise 0.
- **FSM states:** HALT, RUN, STEP, BREAK, DONE.
- **HALT:**
  - `run_sw_s`=1 → RUN with `skip_bp` set.
  - Else `step_pulse` → STEP.
  - If both occur in the same cycle, RUN wins.
- **RUN:**
  - `halt_hit` → DONE.
  - Else `bp_hit` → BREAK; the breakpoint instruction is not executed.
  - Else `run_sw_s`=0 → HALT.
  - `skip_bp` clears after the first RUN cycle, so resuming at `bp_addr` does not re-break immediately.
- **STEP:** lasts exactly one cycle and ignores breakpoints.
  - `halt_hit` → DONE.
  - Otherwise → HALT.
- **BREAK:**
  - `step_pulse` → STEP, which executes the breakpoint instruction.
  - `run_sw_s`=0 → HALT.
  - `run_sw_s`=1 alone keeps the FSM in BREAK.
- **DONE:** absorbing; only `reset` exits it.
- **Ignored step:** `step_pulse` in RUN is ignored.
- **Counters:** `cycle_count` increments every non-reset clock. `retired_count` increments on every `cpu_en`=1 cycle. Both wrap modulo 2^32 with no saturation.

## Timing
- **Reset values:** state=HALT, cpu_en=0, halted=1, done=0, both counters 0, `skip_bp`=0, synchroniser and debounce flops 0.
- **Reset mid-run:** a reset asserted while RUN is active forces HALT on the next edge, with `cpu_en` low in that cycle.
- **Switch latency:** `run_sw` edge → state change after 3 clocks (2 synchroniser + 1 state register). The first enabled cycle follows one clock later.
- **Button latency:** a `step_btn` press is held DEBOUNCE_CYCLES + 2 clocks, then produces `step_pulse`. STEP is entered on the next edge, giving exactly one `cpu_en` cycle.
- **Breakpoint/halt detection:** same-cycle. `cpu_en` drops in the cycle `pc`/`instr` match, so no write commits for the matched instruction.
- **Counter/flag outputs:** `cycle_count`, `retired_count`, `halted` and `done` are registered.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - state encoding constants HALT/RUN/STEP/BREAK/DONE (3-bit internal),
  - default HALT_INSTR,
  - the 2-bit display encoding for `state`.
- One sub-module, `debounce_pulse`, containing the synchroniser, stability counter of width clog2(DEBOUNCE_CYCLES+1), and rising-edge pulse. It is instantiated for `step_btn`.
- `run_sw` uses the synchroniser only, with no debounce.

## Test plan
- **Reset, then run:** reset, run_sw=1, instr≠HALT_INSTR → state RUN after 3 clocks; `cpu_en` stays 1; after 10 enabled cycles `retired_count`=10.
- **Single step:** in HALT, press step_btn for DEBOUNCE_CYCLES+5 clocks → exactly one `cpu_en` pulse, `retired_count` 0→1, state returns to HALT. A 5-cycle glitch on step_btn → no pulse.
- **Breakpoint:** bp_en=1, bp_addr=32'h0000_0010, running with pc reaching 0x10 → `cpu_en`=0 that cycle, state BREAK, `retired_count` frozen. Then a step → one commit at 0x10, state HALT.
- **Resume past breakpoint:** halt with pc=0x10, bp still armed, set run_sw=1 → first RUN cycle commits (`skip_bp`); re-break occurs only on the next arrival at 0x10.
- **Halt instruction:** instr=32'hFFFF_FFFF while RUN → `cpu_en`=0, `done`=1, state DONE. Toggling run_sw and step_btn has no effect; reset returns to HALT with counters 0.
- **Priority and wrap:** run_sw rise and step_pulse in the same HALT cycle → RUN. Force `retired_count`=32'hFFFF_FFFF, then one enabled cycle → 0.
